// File: rtl/qu_pkg.sv
// Shared types and encodings for the Qu processor front end.
// Covers RV32I field types, major opcodes and the decoded packet layout.
package qu_pkg;

  localparam int QU_PC_WIDTH = 12;

  typedef logic [31:0] instr_t;
  typedef logic [6:0]  opcode_t;
  typedef logic [2:0]  funct3_t;
  typedef logic [6:0]  funct7_t;
  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] imm32_t;

  localparam opcode_t LOAD_OPCODE   = 7'b0000011;
  localparam opcode_t FENCE_OPCODE  = 7'b0001111;
  localparam opcode_t OP_IMM_OPCODE = 7'b0010011;
  localparam opcode_t AUIPC_OPCODE  = 7'b0010111;
  localparam opcode_t STORE_OPCODE  = 7'b0100011;
  localparam opcode_t OP_OPCODE     = 7'b0110011;
  localparam opcode_t LUI_OPCODE    = 7'b0110111;
  localparam opcode_t BRANCH_OPCODE = 7'b1100011;
  localparam opcode_t JALR_OPCODE   = 7'b1100111;
  localparam opcode_t JAL_OPCODE    = 7'b1101111;
  localparam opcode_t SYSTEM_OPCODE = 7'b1110011;

  localparam funct3_t F3_ADD = 3'b000;
  localparam funct3_t F3_SLL = 3'b001;
  localparam funct3_t F3_SR  = 3'b101;
  localparam funct3_t F3_PRIV = 3'b000;
  localparam funct3_t F3_SYS_RSVD = 3'b100;

  localparam funct7_t F7_BASE = 7'b0000000;
  localparam funct7_t F7_ALT  = 7'b0100000;

  localparam logic [11:0] IMM_ECALL  = 12'h000;
  localparam logic [11:0] IMM_EBREAK = 12'h001;

  // CLS_R is encoded as zero so a cleared packet reads as an R-type shell.
  typedef enum logic [3:0] {
    CLS_R,
    CLS_OP_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC,
    CLS_FENCE,
    CLS_SYSTEM,
    CLS_NONE
  } op_class_t;

  typedef struct packed {
    op_class_t cls;
    funct3_t   funct3;
    funct7_t   funct7;
    reg_addr_t rd;
    reg_addr_t rs1;
    reg_addr_t rs2;
    imm32_t    imm32;
    logic      rd_we;
    logic      rs1_used;
    logic      rs2_used;
    logic      illegal;
  } dec_t;

endpackage

// File: rtl/qu_decode_comb.sv
// Purely combinational RV32I decoder: fields, immediate, class, register use
// and illegal-encoding detection for one instruction word.
module qu_decode_comb
  import qu_pkg::*;
(
  input  instr_t i_instr,
  output dec_t   o_dec
);

  opcode_t   w_opcode;
  funct3_t   w_funct3;
  funct7_t   w_funct7;
  reg_addr_t w_rd;
  reg_addr_t w_rs1;
  reg_addr_t w_rs2;
  imm32_t    w_immI;
  imm32_t    w_immS;
  imm32_t    w_immB;
  imm32_t    w_immJ;
  imm32_t    w_immU;

  op_class_t w_cls;
  imm32_t    w_imm;
  logic      w_rdWe;
  logic      w_rs1Used;
  logic      w_rs2Used;
  logic      w_illegal;

  assign w_opcode = i_instr[6:0];
  assign w_rd     = i_instr[11:7];
  assign w_funct3 = i_instr[14:12];
  assign w_rs1    = i_instr[19:15];
  assign w_rs2    = i_instr[24:20];
  assign w_funct7 = i_instr[31:25];

  assign w_immI = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_immS = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_immB = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                   i_instr[11:8], 1'b0};
  assign w_immJ = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                   i_instr[30:21], 1'b0};
  assign w_immU = {i_instr[31:12], 12'b0};

  always_comb begin
    w_cls     = CLS_NONE;
    w_imm     = '0;
    w_rdWe    = 1'b0;
    w_rs1Used = 1'b0;
    w_rs2Used = 1'b0;
    w_illegal = 1'b0;

    if (i_instr[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      unique case (w_opcode)
        OP_OPCODE: begin
          w_cls     = CLS_R;
          w_rdWe    = 1'b1;
          w_rs1Used = 1'b1;
          w_rs2Used = 1'b1;
          if (w_funct7 != F7_BASE && w_funct7 != F7_ALT)
            w_illegal = 1'b1;
          else if (w_funct7 == F7_ALT && w_funct3 != F3_ADD && w_funct3 != F3_SR)
            w_illegal = 1'b1;
        end
        OP_IMM_OPCODE: begin
          w_cls     = CLS_OP_IMM;
          w_imm     = w_immI;
          w_rdWe    = 1'b1;
          w_rs1Used = 1'b1;
          // Shift-immediates reuse imm[11:5] as a funct7 qualifier.
          if (w_funct3 == F3_SLL && w_funct7 != F7_BASE)
            w_illegal = 1'b1;
          else if (w_funct3 == F3_SR && w_funct7 != F7_BASE && w_funct7 != F7_ALT)
            w_illegal = 1'b1;
        end
        LOAD_OPCODE: begin
          w_cls     = CLS_LOAD;
          w_imm     = w_immI;
          w_rdWe    = 1'b1;
          w_rs1Used = 1'b1;
          if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111)
            w_illegal = 1'b1;
        end
        STORE_OPCODE: begin
          w_cls     = CLS_STORE;
          w_imm     = w_immS;
          w_rs1Used = 1'b1;
          w_rs2Used = 1'b1;
          if (w_funct3 > 3'b010)
            w_illegal = 1'b1;
        end
        BRANCH_OPCODE: begin
          w_cls     = CLS_BRANCH;
          w_imm     = w_immB;
          w_rs1Used = 1'b1;
          w_rs2Used = 1'b1;
          if (w_funct3 == 3'b010 || w_funct3 == 3'b011)
            w_illegal = 1'b1;
        end
        JAL_OPCODE: begin
          w_cls  = CLS_JAL;
          w_imm  = w_immJ;
          w_rdWe = 1'b1;
        end
        JALR_OPCODE: begin
          w_cls     = CLS_JALR;
          w_imm     = w_immI;
          w_rdWe    = 1'b1;
          w_rs1Used = 1'b1;
          if (w_funct3 != 3'b000)
            w_illegal = 1'b1;
        end
        LUI_OPCODE: begin
          w_cls  = CLS_LUI;
          w_imm  = w_immU;
          w_rdWe = 1'b1;
        end
        AUIPC_OPCODE: begin
          w_cls  = CLS_AUIPC;
          w_imm  = w_immU;
          w_rdWe = 1'b1;
        end
        FENCE_OPCODE: begin
          w_cls = CLS_FENCE;
          w_imm = w_immI;
          if (w_funct3 != 3'b000 && w_funct3 != 3'b001)
            w_illegal = 1'b1;
        end
        SYSTEM_OPCODE: begin
          w_cls = CLS_SYSTEM;
          w_imm = w_immI;
          if (w_funct3 == F3_SYS_RSVD) begin
            w_illegal = 1'b1;
          end else if (w_funct3 == F3_PRIV) begin
            if ((i_instr[31:20] != IMM_ECALL && i_instr[31:20] != IMM_EBREAK) ||
                w_rs1 != 5'd0 || w_rd != 5'd0)
              w_illegal = 1'b1;
          end else begin
            // CSR ops: funct3[2] selects the zimm form, where rs1 is a constant.
            w_rdWe    = 1'b1;
            w_rs1Used = ~w_funct3[2];
          end
        end
        default: w_illegal = 1'b1;
      endcase
    end

    if (w_rd == 5'd0)
      w_rdWe = 1'b0;

    if (w_illegal) begin
      w_cls     = CLS_NONE;
      w_imm     = '0;
      w_rdWe    = 1'b0;
      w_rs1Used = 1'b0;
      w_rs2Used = 1'b0;
    end
  end

  assign o_dec = '{cls:      w_cls,
                   funct3:   w_funct3,
                   funct7:   w_funct7,
                   rd:       w_rd,
                   rs1:      w_rs1,
                   rs2:      w_rs2,
                   imm32:    w_imm,
                   rd_we:    w_rdWe,
                   rs1_used: w_rs1Used,
                   rs2_used: w_rs2Used,
                   illegal:  w_illegal};

endmodule

// File: rtl/qu_decode_stage.sv
// Registered decode stage between fetch and issue: one-deep output register
// with valid/ready handshakes, flush, and a saturating decode counter.
module qu_decode_stage
  import qu_pkg::*;
#(
  parameter int PC_WIDTH  = QU_PC_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              instr_i,
  input  logic [PC_WIDTH-1:0]      pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [$bits(dec_t)-1:0]  dec_o,
  output logic [PC_WIDTH-1:0]      pc_o,
  output logic [CNT_WIDTH-1:0]     dec_cnt_o
);

  dec_t                 w_dec;
  logic                 w_inXfer;
  logic                 w_outXfer;

  logic                 r_outValid;
  dec_t                 r_dec;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [CNT_WIDTH-1:0] r_cnt;

  qu_decode_comb u_decode_comb (
    .i_instr (instr_i),
    .o_dec   (w_dec)
  );

  assign in_ready_o = !r_outValid || out_ready_i;
  assign w_inXfer   = in_valid_i && in_ready_o && !flush_i;
  assign w_outXfer  = r_outValid && out_ready_i;

  // Flush wins over both a new load and a consume; payload is only written on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_dec      <= '0;
      r_pc       <= '0;
    end else if (flush_i) begin
      r_outValid <= 1'b0;
    end else if (w_inXfer) begin
      r_outValid <= 1'b1;
      r_dec      <= w_dec;
      r_pc       <= pc_i;
    end else if (w_outXfer) begin
      r_outValid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_inXfer && !w_dec.illegal && r_cnt != {CNT_WIDTH{1'b1}})
      r_cnt <= r_cnt + 1'b1;
  end

  assign out_valid_o = r_outValid;
  assign dec_o       = r_dec;
  assign pc_o        = r_pc;
  assign dec_cnt_o   = r_cnt;

endmodule

// File: tb/tb_qu_decode_stage.sv
// Directed bench for qu_decode_stage with hand-computed expectations.
module tb_qu_decode_stage;
  import qu_pkg::*;

  localparam int PC_W  = 12;
  localparam int CNT_W = 16;

  logic                    clk;
  logic                    rst;
  logic                    flush_i;
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [31:0]             instr_i;
  logic [PC_W-1:0]         pc_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [$bits(dec_t)-1:0] dec_o;
  logic [PC_W-1:0]         pc_o;
  logic [CNT_W-1:0]        dec_cnt_o;

  dec_t dv;
  int   checks = 0;
  int   errors = 0;

  assign dv = dec_o;

  qu_decode_stage #(.PC_WIDTH(PC_W), .CNT_WIDTH(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .pc_i        (pc_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .dec_o       (dec_o),
    .pc_o        (pc_o),
    .dec_cnt_o   (dec_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc);
    in_valid_i = v;
    instr_i    = ins;
    pc_i       = pc;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    applyStimulus(1'b0, 32'h0, '0);
    step();
    checkOutput("rst_in_ready", in_ready_o, 1'b1);
    step();
    rst = 1'b0;
    checkOutput("rst_valid", out_valid_o, 1'b0);
    checkOutput("rst_dec", dec_o, '0);
    checkOutput("rst_pc", pc_o, '0);
    checkOutput("rst_cnt", dec_cnt_o, '0);

    // addi x5,x1,-1
    applyStimulus(1'b1, 32'hFFF08293, 12'h010);
    step();
    applyStimulus(1'b0, 32'h0, '0);
    checkOutput("addi_valid", out_valid_o, 1'b1);
    checkOutput("addi_cls", dv.cls, CLS_OP_IMM);
    checkOutput("addi_rd", dv.rd, 5'd5);
    checkOutput("addi_rs1", dv.rs1, 5'd1);
    checkOutput("addi_imm", dv.imm32, 32'hFFFFFFFF);
    checkOutput("addi_rdwe", dv.rd_we, 1'b1);
    checkOutput("addi_pc", pc_o, 12'h010);
    checkOutput("addi_cnt", dec_cnt_o, 16'd1);

    // beq x1,x2,-4 then jal x1,+2048 back to back
    applyStimulus(1'b1, 32'hFE208EE3, 12'h014);
    step();
    checkOutput("beq_cls", dv.cls, CLS_BRANCH);
    checkOutput("beq_imm", dv.imm32, 32'hFFFFFFFC);
    checkOutput("beq_rs2used", dv.rs2_used, 1'b1);
    checkOutput("beq_rdwe", dv.rd_we, 1'b0);
    applyStimulus(1'b1, 32'h001000EF, 12'h018);
    step();
    applyStimulus(1'b0, 32'h0, '0);
    checkOutput("jal_cls", dv.cls, CLS_JAL);
    checkOutput("jal_imm", dv.imm32, 32'h00000800);
    checkOutput("jal_rdwe", dv.rd_we, 1'b1);
    checkOutput("jal_pc", pc_o, 12'h018);
    checkOutput("jal_cnt", dec_cnt_o, 16'd3);
    step();
    checkOutput("drain_valid", out_valid_o, 1'b0);

    // sub x3,x1,x2 then stall three cycles with addi waiting
    applyStimulus(1'b1, 32'h402081B3, 12'h020);
    step();
    checkOutput("sub_cls", dv.cls, CLS_R);
    checkOutput("sub_cnt", dec_cnt_o, 16'd4);
    out_ready_i = 1'b0;
    applyStimulus(1'b1, 32'hFFF08293, 12'h024);
    #1;
    checkOutput("stall_in_ready", in_ready_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("stall_valid", out_valid_o, 1'b1);
      checkOutput("stall_cls", dv.cls, CLS_R);
      checkOutput("stall_rd", dv.rd, 5'd3);
      checkOutput("stall_rs2", dv.rs2, 5'd2);
      checkOutput("stall_f7", dv.funct7, 7'h20);
      checkOutput("stall_pc", pc_o, 12'h020);
      checkOutput("stall_cnt", dec_cnt_o, 16'd4);
    end
    out_ready_i = 1'b1;
    #1;
    checkOutput("release_in_ready", in_ready_o, 1'b1);
    step();
    checkOutput("release_cls", dv.cls, CLS_OP_IMM);
    checkOutput("release_pc", pc_o, 12'h024);
    checkOutput("release_cnt", dec_cnt_o, 16'd5);

    // Illegal / legal edge encodings
    applyStimulus(1'b1, 32'h00000000, 12'h028);
    step();
    checkOutput("zero_illegal", dv.illegal, 1'b1);
    checkOutput("zero_cls", dv.cls, CLS_NONE);
    checkOutput("zero_rdwe", dv.rd_we, 1'b0);
    checkOutput("zero_valid", out_valid_o, 1'b1);
    checkOutput("zero_cnt", dec_cnt_o, 16'd5);
    applyStimulus(1'b1, 32'h4000D0B3, 12'h02C);
    step();
    checkOutput("sra_illegal", dv.illegal, 1'b0);
    checkOutput("sra_cls", dv.cls, CLS_R);
    checkOutput("sra_rdwe", dv.rd_we, 1'b1);
    checkOutput("sra_cnt", dec_cnt_o, 16'd6);
    applyStimulus(1'b1, 32'h40001033, 12'h030);
    step();
    checkOutput("subsll_illegal", dv.illegal, 1'b1);
    checkOutput("subsll_rdwe", dv.rd_we, 1'b0);
    checkOutput("subsll_rs1used", dv.rs1_used, 1'b0);
    checkOutput("subsll_cnt", dec_cnt_o, 16'd6);

    // Flush with a simultaneous input and output transfer
    flush_i = 1'b1;
    applyStimulus(1'b1, 32'hFFF08293, 12'h034);
    step();
    flush_i = 1'b0;
    applyStimulus(1'b0, 32'h0, '0);
    checkOutput("flush_valid", out_valid_o, 1'b0);
    checkOutput("flush_cnt", dec_cnt_o, 16'd6);

    // Reset in the middle of a stall
    applyStimulus(1'b1, 32'h402081B3, 12'h038);
    step();
    checkOutput("pre_rst_cnt", dec_cnt_o, 16'd7);
    out_ready_i = 1'b0;
    step();
    checkOutput("pre_rst_pc", pc_o, 12'h038);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready_i = 1'b1;
    applyStimulus(1'b0, 32'h0, '0);
    checkOutput("midrst_valid", out_valid_o, 1'b0);
    checkOutput("midrst_dec", dec_o, '0);
    checkOutput("midrst_pc", pc_o, '0);
    checkOutput("midrst_cnt", dec_cnt_o, '0);

    // ecall, lw legal; ld (funct3=011) illegal
    applyStimulus(1'b1, 32'h00000073, 12'h040);
    step();
    checkOutput("ecall_cls", dv.cls, CLS_SYSTEM);
    checkOutput("ecall_illegal", dv.illegal, 1'b0);
    checkOutput("ecall_rdwe", dv.rd_we, 1'b0);
    applyStimulus(1'b1, 32'h0040A103, 12'h044);
    step();
    checkOutput("lw_cls", dv.cls, CLS_LOAD);
    checkOutput("lw_imm", dv.imm32, 32'h00000004);
    checkOutput("lw_rdwe", dv.rd_we, 1'b1);
    applyStimulus(1'b1, 32'h0040B103, 12'h048);
    step();
    checkOutput("ld_illegal", dv.illegal, 1'b1);
    checkOutput("ld_cnt", dec_cnt_o, 16'd2);

    // Drive the counter to saturation
    applyStimulus(1'b1, 32'hFFF08293, 12'h050);
    for (int i = 0; i < 65532; i++) step();
    checkOutput("cnt_fffe", dec_cnt_o, 16'hFFFE);
    step();
    checkOutput("cnt_sat1", dec_cnt_o, 16'hFFFF);
    step();
    step();
    checkOutput("cnt_sat3", dec_cnt_o, 16'hFFFF);
    applyStimulus(1'b0, 32'h0, '0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qu_decode_stage.md
Name: qu_decode_stage

Overview:
Registered instruction decode stage for the Qu processor. It sits between fetch and issue and accepts one 32-bit RV32I instruction and its PC per valid/ready handshake. It splits the word into fields and rebuilds the sign-extended 32-bit immediate for the instruction format. It classifies the instruction, flags illegal encodings, and presents the result one cycle later behind an output valid/ready handshake. It also keeps a saturating count of decoded instructions.

Parameters:
PC_WIDTH, QU_PC_WIDTH (12), width of pc_i/pc_o
CNT_WIDTH, 16, width of the decoded-instruction counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush_i  in  1  discard the held output and any transfer in the same cycle
in_valid_i  in  1  instr_i/pc_i valid
in_ready_o  out  1  stage can accept input
instr_i  in  32  instruction word (instr_t)
pc_i  in  PC_WIDTH  instruction address
out_valid_o  out  1  decoded output valid
out_ready_i  in  1  consumer accepts output
dec_o  out  $bits(dec_t)  decoded packet (dec_t)
pc_o  out  PC_WIDTH  PC of the decoded instruction
dec_cnt_o  out  CNT_WIDTH  number of accepted non-illegal decodes, saturating

Behaviour:
- Reset and interface:
  - One clock; reset is synchronous and active-high. On rst, out_valid_o=0, dec_o='0, pc_o=0 and dec_cnt_o=0.
  - in_ready_o = !out_valid_o || out_ready_i. It is combinational and also true during rst.
- Input and output transfers:
  - An input transfer happens when in_valid_i && in_ready_o && !flush_i. On the next edge the output register loads the decoded packet and pc_i, and out_valid_o goes to 1. Latency is 1 cycle, with full throughput when out_ready_i is held at 1.
  - Output consumed with no new input transfer: out_valid_o falls to 0 on the next edge.
  - Stall (out_valid_o && !out_ready_i): dec_o and pc_o are held bit-stable.
- Flush:
  - flush_i forces out_valid_o to 0 on the next edge.
  - Flush dominates a simultaneous input transfer and a simultaneous output acceptance.
  - A flushed instruction does not count.
- Packet fields:
  - op class enum: R, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, FENCE, SYSTEM, NONE.
  - Register fields: funct3, funct7, rd, rs1, rs2.
  - imm32.
  - Control flags: rd_we, rs1_used, rs2_used, illegal.
- Immediate rules (all sign-extended to 32 bits):
  - I: instr[31:20]
  - S: {instr[31:25],instr[11:7]}
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}
  - U: {instr[31:12],12'b0}
  - R and NONE: imm32=0
- Register-use rules:
  - rd_we=1 for R, OP_IMM, LOAD, JAL, JALR, LUI, AUIPC and CSR ops, but only when rd≠0. Otherwise rd_we=0.
  - rs1_used=1 for R, OP_IMM, LOAD, STORE, BRANCH, JALR and register-form CSR.
  - rs2_used=1 for R, STORE and BRANCH.
- Illegal rules (illegal=1 forces rd_we=0, rs1_used=0, rs2_used=0 and class NONE):
  - instr[1:0]≠11, or unknown opcode.
  - R with funct7 outside {0000000, 0100000}, or funct7=0100000 with funct3 ∉ {ADD, SRA}.
  - SLLI with funct7≠0; SRLI/SRAI with funct7 ∉ {0000000, 0100000}.
  - LOAD funct3 ∈ {011, 110, 111}; STORE funct3 > 010; BRANCH funct3 ∈ {010, 011}; JALR funct3≠000.
  - FENCE funct3 ∉ {000, 001}.
  - SYSTEM funct3=100; SYSTEM funct3=000 with imm12 ∉ {IMM_ECALL, IMM_EBREAK} or rs1/rd≠0.
- Counter: dec_cnt_o increments on each input transfer whose decode is not illegal. It saturates at all-ones and does not wrap.

Decomposition:
- Add to qu_pkg:
  - LOAD_OPCODE=7'b0000011.
  - Enum op_class_t.
  - Packed struct dec_t {op_class_t cls; funct3_t funct3; funct7_t funct7; reg_addr_t rd, rs1, rs2; imm32_t imm32; logic rd_we, rs1_used, rs2_used, illegal;}.
- One purely combinational sub-module, qu_decode_comb (instr_t in, dec_t out). qu_decode_stage adds the pipeline register, handshake, flush and counter.

Test Plan:
- addi x5,x1,-1 (0xFFF08293), out_ready_i=1 -> next cycle out_valid_o=1, cls=OP_IMM, rd=5, rs1=1, imm32=0xFFFFFFFF, rd_we=1, dec_cnt_o=1.
- beq x1,x2,-4 (0xFE208EE3), then jal x1,+2048 (0x001000EF) -> imm32=0xFFFFFFFC with rs2_used=1, then imm32=0x00000800 with rd_we=1.
- Send sub x3,x1,x2 and hold out_ready_i=0 for 3 cycles with in_valid_i=1 -> in_ready_o=0, dec_o stable; releasing out_ready_i accepts the next instruction in the same cycle.
- 0x00000000, 0x4000D0B3 (funct7=0100000 on SRL is legal = SRA), 0x40001033 (SUB-funct7 on SLL) -> illegal=1 for the first and third words, rd_we=0, dec_cnt_o not incremented.
- flush_i asserted together with in_valid_i and out_valid_o=1 -> next cycle out_valid_o=0, dec_cnt_o unchanged; rst mid-stall -> all outputs 0 next cycle.
- Force dec_cnt_o to 0xFFFE via 0xFFFE legal decodes, then send 3 more -> dec_cnt_o stops at 0xFFFF.
